// File: rtl/fetch_axil_prefetch.sv
// Instruction fetch unit: issues sequential AXI-Lite reads, tags each read with
// the fetch epoch, and buffers accepted {instr, pc, fault} entries in a queue
// whose free space is reserved at issue time so it can never overflow.
module fetch_axil_prefetch #(
    parameter int          QUE_ADDR_WIDTH  = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_PC         = 32'h0,
    parameter bit          SWAP_ENDIAN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        flush,
    input  logic [31:0] pc_bj,
    input  logic        ecall_retire,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        fetch_fault,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    localparam int          DEPTH    = 1 << QUE_ADDR_WIDTH;
    localparam int          TW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        ECALL_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        epoch;
    logic [31:0] fetch_pc;
    logic [2:0]  outstanding;

    // in-flight tag FIFO: epoch and PC of every issued, unanswered read
    logic          tag_epoch [MAX_OUTSTANDING];
    logic [31:0]   tag_pc    [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr, tag_rd;

    // fetched-entry queue
    logic [31:0]               q_instr [DEPTH];
    logic [31:0]               q_pc    [DEPTH];
    logic                      q_fault [DEPTH];
    logic [QUE_ADDR_WIDTH-1:0] q_wr, q_rd;
    logic [QUE_ADDR_WIDTH:0]   q_count;

    logic        ar_hs, r_hs, r_accept, ecall_hit, pop, issue, run_en, credit_ok;
    logic [31:0] rdata_sw;
    logic [7:0]  inflight;

    assign rready   = 1'b1;
    assign ar_hs    = arvalid & arready;
    assign r_hs     = rvalid;
    assign rdata_sw = SWAP_ENDIAN ? {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]} : rdata;
    assign r_accept = r_hs & (tag_epoch[tag_rd] == epoch) & ~flush;
    assign ecall_hit = r_accept & (rdata_sw == ECALL);
    assign pop      = instr_valid & ~stall;
    assign run_en   = (state == RUN) | ((state == IDLE) & go);

    // Reads in flight include the AR still waiting for arready; an R beat this
    // cycle frees its slot so back-to-back issue is possible at 1-cycle latency.
    assign inflight  = 8'(outstanding) + 8'(arvalid);
    assign credit_ok = (inflight < 8'(MAX_OUTSTANDING) + 8'(r_hs)) &&
                       (8'(q_count) + inflight < 8'(DEPTH));
    assign issue     = run_en & ~flush & ~ecall_hit & (~arvalid | arready) & credit_ok;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: flush redirects from any state; IDLE only leaves on go
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = (state == IDLE && !go) ? IDLE : RUN;
        end else begin
            case (state)
                IDLE:       if (go) state_nxt = RUN;
                RUN:        if (ecall_hit) state_nxt = ECALL_WAIT;
                ECALL_WAIT: if (ecall_retire) state_nxt = IDLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // AR channel, fetch PC, epoch and outstanding-read counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid     <= 1'b0;
            araddr      <= BOOT_PC;
            fetch_pc    <= BOOT_PC;
            epoch       <= 1'b0;
            outstanding <= '0;
        end else begin
            if (issue) begin
                arvalid <= 1'b1;
                araddr  <= fetch_pc;
            end else if (ar_hs) begin
                arvalid <= 1'b0;
            end
            // ECALL rewinds to the instruction after it, undoing run-ahead
            if (flush)          fetch_pc <= pc_bj;
            else if (ecall_hit) fetch_pc <= tag_pc[tag_rd] + 32'd4;
            else if (issue)     fetch_pc <= fetch_pc + 32'd4;
            epoch <= epoch ^ (flush | ecall_hit);
            case ({ar_hs, r_hs})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // tag FIFO pointers: push on issue, pop on every R beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (issue) tag_wr <= tag_next(tag_wr);
            if (r_hs)  tag_rd <= tag_next(tag_rd);
        end
    end

    // tag FIFO storage
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_epoch[tag_wr] <= epoch;
            tag_pc[tag_wr]    <= fetch_pc;
        end
    end

    // queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else if (flush) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else begin
            if (r_accept) q_wr <= q_wr + QUE_ADDR_WIDTH'(1);
            if (pop)      q_rd <= q_rd + QUE_ADDR_WIDTH'(1);
            if (r_accept && !pop)      q_count <= q_count + (QUE_ADDR_WIDTH + 1)'(1);
            else if (!r_accept && pop) q_count <= q_count - (QUE_ADDR_WIDTH + 1)'(1);
        end
    end

    // queue storage
    always_ff @(posedge clk) begin
        if (r_accept) begin
            q_instr[q_wr] <= rdata_sw;
            q_pc[q_wr]    <= tag_pc[tag_rd];
            q_fault[q_wr] <= (rresp != 2'b00);
        end
    end

    // output: queue head, masked to NOP/0 when empty or flushing
    always_comb begin
        instr_valid = 1'b0;
        instr       = NOP_INSN;
        pc_out      = '0;
        fetch_fault = 1'b0;
        if (q_count != '0 && !flush) begin
            instr_valid = 1'b1;
            instr       = q_instr[q_rd];
            pc_out      = q_pc[q_rd];
            fetch_fault = q_fault[q_rd];
        end
    end

endmodule
